fpu_dp_cmd_seq: RTL and testbench

//  Command sequencer upstream of the double-precision FPU top (add/mul/div).

---
 rtl/fpu_dp_cmd_seq.sv | 185 ++++++++++++++++++
 tb/tb_fpu_dp_cmd_seq.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_dp_cmd_seq.sv
// Command sequencer in front of the double-precision FPU.
// Queues host requests, issues one at a time, returns tagged results.
module fpu_dp_cmd_seq #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_cmd,
  input  logic [63:0]      req_din1,
  input  logic [63:0]      req_din2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [1:0]       rsp_err,
  output logic [3:0]       fpu_cmd,
  output logic [63:0]      fpu_din1,
  output logic [63:0]      fpu_din2,
  output logic             fpu_dval,
  input  logic [63:0]      fpu_result,
  input  logic             fpu_rdy,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  logic [3:0]       r_q_cmd  [DEPTH];
  logic [63:0]      r_q_din1 [DEPTH];
  logic [63:0]      r_q_din2 [DEPTH];
  logic [TAG_W-1:0] r_q_tag  [DEPTH];
  logic [AW:0]      r_wp;
  logic [AW:0]      r_rp;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [TAG_W-1:0] r_tag;
  logic [3:0]       r_cmd;
  logic [63:0]      r_din1;
  logic [63:0]      r_din2;
  logic             r_dval;
  logic             r_rsp_valid;
  logic [63:0]      r_rsp_result;
  logic [TAG_W-1:0] r_rsp_tag;
  logic [1:0]       r_rsp_err;

  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [3:0]       w_head_cmd;
  logic             w_head_sup;

  assign w_empty = (r_wp == r_rp);
  assign w_full  = (r_wp[AW] != r_rp[AW]) &&
                   (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_push  = req_valid && !w_full;
  assign w_pop   = (r_state == S_IDLE) && !w_empty;

  assign w_head_cmd = r_q_cmd[r_rp[AW-1:0]];
  assign w_head_sup = (w_head_cmd == 4'b0101) ||
                      (w_head_cmd == 4'b0110) ||
                      (w_head_cmd == 4'b0111);

  // FIFO storage; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_cmd[r_wp[AW-1:0]]  <= req_cmd;
      r_q_din1[r_wp[AW-1:0]] <= req_din1;
      r_q_din2[r_wp[AW-1:0]] <= req_din2;
      r_q_tag[r_wp[AW-1:0]]  <= req_tag;
    end
  end

  // FIFO pointers with wrap bit for full/empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  // Issue FSM; FPU drive and response port are all registered here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_tag        <= '0;
      r_cmd        <= '0;
      r_din1       <= '0;
      r_din2       <= '0;
      r_dval       <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_tag    <= '0;
      r_rsp_err    <= '0;
    end else begin
      r_dval <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_tag <= r_q_tag[r_rp[AW-1:0]];
            if (w_head_sup) begin
              r_cmd   <= w_head_cmd;
              r_din1  <= r_q_din1[r_rp[AW-1:0]];
              r_din2  <= r_q_din2[r_rp[AW-1:0]];
              r_dval  <= 1'b1;
              r_state <= S_ISSUE;
            end else begin
              r_rsp_valid  <= 1'b1;
              r_rsp_result <= '0;
              r_rsp_tag    <= r_q_tag[r_rp[AW-1:0]];
              r_rsp_err    <= 2'b01;
              r_state      <= S_RESP;
            end
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (fpu_rdy) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_result <= fpu_result;
            r_rsp_tag    <= r_tag;
            r_rsp_err    <= 2'b00;
            r_cmd        <= '0;
            r_din1       <= '0;
            r_din2       <= '0;
            r_state      <= S_RESP;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_result <= '0;
            r_rsp_tag    <= r_tag;
            r_rsp_err    <= 2'b10;
            r_cmd        <= '0;
            r_din1       <= '0;
            r_din2       <= '0;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_tag    <= '0;
            r_rsp_err    <= '0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = !w_full;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_tag    = r_rsp_tag;
  assign rsp_err    = r_rsp_err;
  assign fpu_cmd    = r_cmd;
  assign fpu_din1   = r_din1;
  assign fpu_din2   = r_din2;
  assign fpu_dval   = r_dval;
  assign busy       = !w_empty || (r_state != S_IDLE);

endmodule

// File: tb/tb_fpu_dp_cmd_seq.sv
// Directed bench for fpu_dp_cmd_seq with a simple in-line FPU model.
// DUT built with TIMEOUT=8 so the timeout path is short.
module tb_fpu_dp_cmd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_cmd;
  logic [63:0] req_din1;
  logic [63:0] req_din2;
  logic [3:0]  req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic [1:0]  rsp_err;
  logic [3:0]  fpu_cmd;
  logic [63:0] fpu_din1;
  logic [63:0] fpu_din2;
  logic        fpu_dval;
  logic [63:0] fpu_result;
  logic        fpu_rdy;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;
  int n_dval = 0;

  // FPU model controls
  bit          fpu_auto = 1'b0;
  int          fpu_lat  = 2;
  int          fpu_cd   = 0;
  bit          use_fix  = 1'b0;
  logic [63:0] fix_val  = '0;

  fpu_dp_cmd_seq #(
    .DEPTH(4),
    .TAG_W(4),
    .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_cmd(req_cmd),
    .req_din1(req_din1),
    .req_din2(req_din2),
    .req_tag(req_tag),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_result(rsp_result),
    .rsp_tag(rsp_tag),
    .rsp_err(rsp_err),
    .fpu_cmd(fpu_cmd),
    .fpu_din1(fpu_din1),
    .fpu_din2(fpu_din2),
    .fpu_dval(fpu_dval),
    .fpu_result(fpu_result),
    .fpu_rdy(fpu_rdy),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: advance past the edge, then play the FPU side
  task automatic tick();
    @(posedge clk);
    #1;
    fpu_rdy = 1'b0;
    if (fpu_dval) n_dval++;
    if (fpu_auto && fpu_dval) begin
      fpu_cd = fpu_lat;
    end else if (fpu_cd > 0) begin
      fpu_cd--;
      if (fpu_cd == 0) begin
        fpu_rdy    = 1'b1;
        fpu_result = use_fix ? fix_val : (fpu_din1 ^ fpu_din2);
      end
    end
  endtask

  task automatic push(input logic [3:0] c, input logic [63:0] a,
                      input logic [63:0] b, input logic [3:0] t);
    req_valid = 1'b1;
    req_cmd   = c;
    req_din1  = a;
    req_din2  = b;
    req_tag   = t;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  logic [3:0]  got_tag [5];
  logic [63:0] got_res [5];
  logic [1:0]  got_err [5];
  logic [63:0] h_res;
  logic [3:0]  h_tag;
  logic [1:0]  h_err;
  int          k;
  int          d0;
  int          acc;
  int          nrsp;

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_cmd    = '0;
    req_din1   = '0;
    req_din2   = '0;
    req_tag    = '0;
    rsp_ready  = 1'b0;
    fpu_result = '0;
    fpu_rdy    = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_dval", 64'(fpu_dval), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fpu_cmd", 64'(fpu_cmd), 64'd0);
    rst = 1'b0;
    tick();

    // add 1.0 + 2.0, FPU answers 4 cycles after dval
    fpu_auto = 1'b1;
    fpu_lat  = 4;
    use_fix  = 1'b1;
    fix_val  = 64'h4008000000000000;
    d0 = n_dval;
    push(4'b0101, 64'h3FF0000000000000, 64'h4000000000000000, 4'd3);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_no_dval_yet", 64'(fpu_dval), 64'd0);
    tick();
    chk("t1_dval", 64'(fpu_dval), 64'd1);
    chk("t1_cmd", 64'(fpu_cmd), 64'h5);
    chk("t1_din1", fpu_din1, 64'h3FF0000000000000);
    chk("t1_din2", fpu_din2, 64'h4000000000000000);
    k = 0;
    while (!rsp_valid && k < 50) begin
      tick();
      k++;
      if (!rsp_valid) chk("t1_cmd_held", 64'(fpu_cmd), 64'h5);
    end
    chk("t1_rsp_latency", 64'(k), 64'd5);
    chk("t1_result", rsp_result, 64'h4008000000000000);
    chk("t1_tag", 64'(rsp_tag), 64'd3);
    chk("t1_err", 64'(rsp_err), 64'd0);
    chk("t1_cmd_cleared", 64'(fpu_cmd), 64'd0);
    chk("t1_one_dval", 64'(n_dval - d0), 64'd1);
    handshake();
    chk("t1_rsp_done", 64'(rsp_valid), 64'd0);

    // unsupported opcode: no issue, error response at N+2
    d0 = n_dval;
    push(4'b0001, 64'h1, 64'h2, 4'd5);
    chk("t3_no_rsp_n1", 64'(rsp_valid), 64'd0);
    tick();
    chk("t3_rsp_n2", 64'(rsp_valid), 64'd1);
    chk("t3_err", 64'(rsp_err), 64'd1);
    chk("t3_result", rsp_result, 64'd0);
    chk("t3_tag", 64'(rsp_tag), 64'd5);
    chk("t3_no_dval", 64'(n_dval - d0), 64'd0);
    handshake();

    // fill FIFO while responses are blocked
    use_fix = 1'b0;
    fpu_lat = 2;
    acc = 0;
    k = 0;
    while (acc < 5 && k < 40) begin
      req_valid = 1'b1;
      req_cmd   = 4'b0110;
      req_din1  = 64'h1111000000000000 | 64'(acc);
      req_din2  = 64'h0000222200000000;
      req_tag   = 4'(acc);
      if (req_ready) begin
        acc++;
        tick();
      end else begin
        tick();
      end
      k++;
    end
    chk("t2_accepts", 64'(acc), 64'd5);
    chk("t2_full", 64'(req_ready), 64'd0);
    // extra request must not get in while full
    req_tag  = 4'd9;
    req_din1 = 64'hDEAD;
    k = 0;
    while (!rsp_valid && k < 20) begin
      tick();
      k++;
    end
    chk("t5_rsp_up", 64'(rsp_valid), 64'd1);
    h_res = rsp_result;
    h_tag = rsp_tag;
    h_err = rsp_err;
    d0 = n_dval;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_valid", 64'(rsp_valid), 64'd1);
      chk("t5_result", rsp_result, h_res);
      chk("t5_tag", 64'(rsp_tag), 64'(h_tag));
      chk("t5_err", 64'(rsp_err), 64'(h_err));
      chk("t2_still_full", 64'(req_ready), 64'd0);
    end
    chk("t5_no_dval", 64'(n_dval - d0), 64'd0);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    nrsp = 0;
    k = 0;
    while (nrsp < 5 && k < 300) begin
      if (rsp_valid) begin
        got_tag[nrsp] = rsp_tag;
        got_res[nrsp] = rsp_result;
        got_err[nrsp] = rsp_err;
        nrsp++;
      end
      tick();
      k++;
    end
    rsp_ready = 1'b0;
    chk("t2_nrsp", 64'(nrsp), 64'd5);
    for (int i = 0; i < 5; i++) begin
      chk("t2_order_tag", 64'(got_tag[i]), 64'(i));
      chk("t2_res", got_res[i],
          (64'h1111000000000000 | 64'(i)) ^ 64'h0000222200000000);
      chk("t2_err", 64'(got_err[i]), 64'd0);
    end
    repeat (4) tick();
    chk("t2_no_extra", 64'(rsp_valid), 64'd0);
    chk("t2_idle", 64'(busy), 64'd0);

    // timeout: FPU silent, 8 WAIT cycles then err 10
    fpu_auto = 1'b0;
    push(4'b0111, 64'h5, 64'h6, 4'd7);
    tick();
    chk("t4_dval", 64'(fpu_dval), 64'd1);
    k = 0;
    while (!rsp_valid && k < 50) begin
      tick();
      k++;
    end
    chk("t4_latency", 64'(k), 64'd9);
    chk("t4_err", 64'(rsp_err), 64'd2);
    chk("t4_result", rsp_result, 64'd0);
    chk("t4_tag", 64'(rsp_tag), 64'd7);
    handshake();
    fpu_result = 64'hDEADBEEF;
    fpu_rdy    = 1'b1;
    tick();
    chk("t4_stale_ignored", 64'(rsp_valid), 64'd0);
    chk("t4_stale_busy", 64'(busy), 64'd0);
    fpu_auto = 1'b1;
    fpu_lat  = 3;
    use_fix  = 1'b1;
    fix_val  = 64'h4018000000000000;
    push(4'b0110, 64'h4000000000000000, 64'h4008000000000000, 4'd8);
    k = 0;
    while (!rsp_valid && k < 50) begin
      tick();
      k++;
    end
    chk("t4_next_err", 64'(rsp_err), 64'd0);
    chk("t4_next_res", rsp_result, 64'h4018000000000000);
    chk("t4_next_tag", 64'(rsp_tag), 64'd8);
    handshake();

    // reset in the middle of WAIT
    fpu_auto = 1'b0;
    push(4'b0101, 64'h7, 64'h8, 4'd2);
    tick();
    tick();
    chk("t6_in_wait", 64'(fpu_cmd), 64'h5);
    rst = 1'b1;
    tick();
    chk("t6_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t6_dval", 64'(fpu_dval), 64'd0);
    chk("t6_cmd", 64'(fpu_cmd), 64'd0);
    chk("t6_din1", fpu_din1, 64'd0);
    chk("t6_tag", 64'(rsp_tag), 64'd0);
    chk("t6_req_ready", 64'(req_ready), 64'd1);
    chk("t6_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    fpu_result = 64'h1234;
    fpu_rdy    = 1'b1;
    nrsp = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid) nrsp++;
    end
    chk("t6_no_rsp", 64'(nrsp), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
